// File: rtl/accu_rr_sched.sv
// Round-robin scheduler that shares one XOR-accumulate datapath among NUM_REQ requesters.
// A granted requester keeps the grant for BURST_LEN beats; the folded result leaves on a valid/ready port.
module accu_rr_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 8,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  output logic                      busy
);

  localparam int CNT_W = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [ID_W-1:0]  ID_MAX   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_grant;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [ID_W-1:0]   r_out_id;

  logic [DATA_W-1:0] w_beats [NUM_REQ];
  logic [DATA_W-1:0] w_beat;
  logic [ID_W-1:0]   w_pick;
  logic              w_any;
  logic              w_accept;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign w_beats[gi]   = req_data[gi*DATA_W +: DATA_W];
    assign req_ready[gi] = (r_state == S_COLLECT) && (r_grant == ID_W'(gi));
  end

  assign w_beat   = w_beats[r_grant];
  assign w_accept = (r_state == S_COLLECT) && req_valid[r_grant];

  // Scan downward in priority so the requester closest to r_rr_ptr is written last and wins.
  always_comb begin : arb
    int idx;
    idx    = 0;
    w_pick = '0;
    w_any  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        w_pick = ID_W'(idx);
        w_any  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_accept) begin
            if (r_cnt == CNT_LAST) begin
              r_out_data  <= r_acc ^ w_beat;
              r_out_id    <= r_grant;
              r_out_valid <= 1'b1;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_rr_ptr    <= (r_grant == ID_MAX) ? '0 : r_grant + ID_W'(1);
              r_state     <= S_DRAIN;
            end else begin
              r_acc <= r_acc ^ w_beat;
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_accu_rr_sched.sv
// Directed bench for accu_rr_sched: a cycle table for one burst, then hand-written
// sequences for contention, backpressure, valid gaps, mid-burst reset and pointer wrap.
module tb_accu_rr_sched;
  localparam int NR = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;
  logic            busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] pat [8];

  typedef struct {
    logic [3:0] vld;
    logic [7:0] d1;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_id;
    logic       e_busy;
  } vec_t;
  vec_t vt [12];

  always #5 clk = ~clk;

  accu_rr_sched #(.NUM_REQ(4), .DATA_W(8), .BURST_LEN(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] vld);
    rst_n     = 1'b0;
    req_valid = vld;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Waits for the grant, feeds pat[] into the granted slot, then drains the result
  // after holding out_ready low for `hold` DRAIN cycles. Returns in the following IDLE cycle.
  task automatic run_burst(input int id, input logic [7:0] exp_d, input int hold, input string tag);
    int n;
    int beats;
    out_ready = (hold == 0);
    n = 0;
    while (req_ready == '0 && n < 30) begin
      step();
      n++;
    end
    chk({tag, ".grant"}, 32'(req_ready), 32'(1 << id));
    beats = 0;
    n = 0;
    while (!out_valid && n < 40) begin
      if (req_ready[id]) begin
        req_data[id*DW +: DW] = pat[beats & 7];
        beats++;
      end
      step();
      n++;
    end
    chk({tag, ".beats"}, 32'(beats), 32'd8);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"},  32'(out_data), 32'(exp_d));
    chk({tag, ".id"},    32'(out_id), 32'(id));
    chk({tag, ".rdy0"},  32'(req_ready), 32'd0);
    chk({tag, ".busy"},  32'(busy), 32'd1);
    for (int k = 1; k < hold; k++) begin
      step();
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_data"},  32'(out_data), 32'(exp_d));
      chk({tag, ".hold_id"},    32'(out_id), 32'(id));
      chk({tag, ".hold_rdy"},   32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk({tag, ".done"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;

    // single burst from requester 1, one row per cycle
    vt[0] = '{vld: 4'b0010, d1: 8'h00, e_rdy: 4'b0000, e_ov: 1'b0, e_od: 8'h00, e_id: 2'd0, e_busy: 1'b0};
    for (int i = 1; i <= 8; i++)
      vt[i] = '{vld: 4'b0010, d1: 8'(i), e_rdy: 4'b0010, e_ov: 1'b0, e_od: 8'h00, e_id: 2'd0, e_busy: 1'b1};
    vt[9]  = '{vld: 4'b0000, d1: 8'h00, e_rdy: 4'b0000, e_ov: 1'b1, e_od: 8'h08, e_id: 2'd1, e_busy: 1'b1};
    vt[10] = '{vld: 4'b0000, d1: 8'h00, e_rdy: 4'b0000, e_ov: 1'b0, e_od: 8'h08, e_id: 2'd1, e_busy: 1'b0};
    vt[11] = vt[10];

    #12;
    chk("reset.valid", 32'(out_valid), 32'd0);
    chk("reset.data",  32'(out_data), 32'd0);
    chk("reset.id",    32'(out_id), 32'd0);
    chk("reset.rdy",   32'(req_ready), 32'd0);
    chk("reset.busy",  32'(busy), 32'd0);
    step();
    rst_n = 1'b1;

    for (int r = 0; r < 12; r++) begin
      req_valid = vt[r].vld;
      req_data  = {16'h0000, vt[r].d1, 8'h00};
      chk($sformatf("vec%0d.rdy", r),   32'(req_ready), 32'(vt[r].e_rdy));
      chk($sformatf("vec%0d.valid", r), 32'(out_valid), 32'(vt[r].e_ov));
      chk($sformatf("vec%0d.data", r),  32'(out_data),  32'(vt[r].e_od));
      chk($sformatf("vec%0d.id", r),    32'(out_id),    32'(vt[r].e_id));
      chk($sformatf("vec%0d.busy", r),  32'(busy),      32'(vt[r].e_busy));
      $display("vec %0d: rdy=%b valid=%b data=%h id=%0d busy=%b", r, req_ready, out_valid, out_data, out_id, busy);
      step();
    end

    // full contention: identical beats cancel, grants rotate 0,1,2,3,0
    req_data = {4{8'h5A}};
    for (int i = 0; i < 8; i++) pat[i] = 8'h5A;
    do_reset(4'b1111);
    run_burst(0, 8'h00, 0, "cont0");
    run_burst(1, 8'h00, 0, "cont1");
    run_burst(2, 8'h00, 0, "cont2");
    run_burst(3, 8'h00, 0, "cont3");
    run_burst(0, 8'h00, 0, "cont4");
    $display("contention: grant order 0,1,2,3,0 done");

    // result backpressure, next grant two cycles after out_ready rises
    for (int i = 0; i < 8; i++) pat[i] = 8'(i + 1);
    do_reset(4'b0011);
    run_burst(0, 8'h08, 5, "bp");
    chk("bp.idle_rdy", 32'(req_ready), 32'd0);
    step();
    chk("bp.next_grant", 32'(req_ready), 32'b0010);
    run_burst(1, 8'h08, 0, "bp2");
    $display("backpressure: done");

    // valid gap on requester 2 while requester 3 waits
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h44; pat[3] = 8'h88;
    pat[4] = 8'h10; pat[5] = 8'h20; pat[6] = 8'h40; pat[7] = 8'h80;
    out_ready = 1'b1;
    do_reset(4'b1100);
    n = 0;
    while (req_ready == '0 && n < 20) begin
      step();
      n++;
    end
    chk("gap.grant", 32'(req_ready), 32'b0100);
    for (int b = 0; b < 4; b++) begin
      req_data[23:16] = pat[b];
      step();
    end
    req_valid[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("gap.hold_rdy", 32'(req_ready), 32'b0100);
      chk("gap.no_out", 32'(out_valid), 32'd0);
      step();
    end
    req_valid[2] = 1'b1;
    for (int b = 4; b < 8; b++) begin
      req_data[23:16] = pat[b];
      step();
    end
    chk("gap.valid", 32'(out_valid), 32'd1);
    chk("gap.data",  32'(out_data), 32'h0F);
    chk("gap.id",    32'(out_id), 32'd2);
    $display("gap: data=%h id=%0d", out_data, out_id);
    req_valid = 4'b0001;
    step();

    // reset in the middle of a burst from requester 0
    pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h04; pat[3] = 8'h08;
    n = 0;
    while (req_ready == '0 && n < 20) begin
      step();
      n++;
    end
    chk("rst.grant", 32'(req_ready), 32'b0001);
    for (int b = 0; b < 4; b++) begin
      req_data[7:0] = pat[b];
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data",  32'(out_data), 32'd0);
    chk("rst.id",    32'(out_id), 32'd0);
    chk("rst.rdy",   32'(req_ready), 32'd0);
    chk("rst.busy",  32'(busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    chk("rst.release_rdy", 32'(req_ready), 32'd0);
    for (int i = 0; i < 8; i++) pat[i] = 8'hFF;
    run_burst(0, 8'h00, 0, "rst_burst");
    $display("reset mid-burst: done");

    // pointer wrap 3 -> 0
    for (int i = 0; i < 8; i++) pat[i] = 8'(i + 1);
    do_reset(4'b1000);
    run_burst(3, 8'h08, 0, "wrap3");
    req_valid = 4'b1001;
    run_burst(0, 8'h08, 0, "wrap0");
    run_burst(3, 8'h08, 0, "wrap3b");
    $display("pointer wrap: done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
